// File: rtl/timer_multi.sv
// Multi-channel programmable timer. Each channel counts enabled clock edges
// up to its run-time-loadable period and emits a registered one-cycle tick
// plus a sticky flag on expiry, in periodic or one-shot mode.
module timer_multi #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned WIDTH          = 24,
    parameter int unsigned DEFAULT_PERIOD = 1200000,
    localparam int unsigned CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] timer_ena,
    input  logic                load_wr,
    input  logic [CW-1:0]       load_ch,
    input  logic [WIDTH-1:0]    load_period,
    input  logic                load_mode,
    input  logic [CHANNELS-1:0] flag_clr,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] flag,
    output logic [CHANNELS-1:0] busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]       state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] period_q, period_d;
        logic [WIDTH-1:0] last;
        logic             mode_q, mode_d;
        logic             tick_q, tick_d;
        logic             flag_q, flag_d;
        logic             load_hit;

        // Out-of-range channel numbers match no generate index, so they are ignored.
        assign load_hit = load_wr && (load_ch == CW'(i));

        // Terminal count Peff-1; period 0 behaves as period 1.
        assign last = (period_q == '0) ? '0 : period_q - 1'b1;

        // Next-state: load restarts the count, disable re-arms, otherwise count.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            period_d = period_q;
            mode_d   = mode_q;
            tick_d   = 1'b0;
            if (load_hit) begin
                period_d = load_period;
                mode_d   = load_mode;
                cnt_d    = '0;
                if (!timer_ena[i]) begin
                    state_d = ST_IDLE;
                end
            end else if (!timer_ena[i]) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    // IDLE holds counter 0, so the first enabled edge is evaluated like RUN.
                    ST_IDLE, ST_RUN: begin
                        if (cnt_q == last) begin
                            cnt_d   = '0;
                            tick_d  = 1'b1;
                            state_d = mode_q ? ST_DONE : ST_RUN;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                    default: begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                endcase
            end
            // Set wins over a simultaneous clear.
            flag_d = tick_d | (flag_q & ~flag_clr[i]);
        end

        // Channel state registers with asynchronous reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                period_q <= WIDTH'(DEFAULT_PERIOD);
                mode_q   <= 1'b0;
                tick_q   <= 1'b0;
                flag_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                period_q <= period_d;
                mode_q   <= mode_d;
                tick_q   <= tick_d;
                flag_q   <= flag_d;
            end
        end

        assign tick[i] = tick_q;
        assign flag[i] = flag_q;
        assign busy[i] = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: expectations are queued before each edge
// and popped and checked after it.
module tb_timer_multi;

    localparam int unsigned CH = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] timer_ena;
    logic          load_wr;
    logic [1:0]    load_ch;
    logic [7:0]    load_period;
    logic          load_mode;
    logic [CH-1:0] flag_clr;
    logic [CH-1:0] tick;
    logic [CH-1:0] flag;
    logic [CH-1:0] busy;

    typedef struct {
        string      tag;
        logic [2:0] m;
        logic [2:0] t;
        logic [2:0] f;
        logic [2:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    timer_multi #(
        .CHANNELS      (CH),
        .WIDTH         (8),
        .DEFAULT_PERIOD(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .timer_ena  (timer_ena),
        .load_wr    (load_wr),
        .load_ch    (load_ch),
        .load_period(load_period),
        .load_mode  (load_mode),
        .flag_clr   (flag_clr),
        .tick       (tick),
        .flag       (flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic push(input string tag, input logic [2:0] m, input logic [2:0] t,
                        input logic [2:0] f, input logic [2:0] b);
        exp_t e;
        e.tag = tag;
        e.m   = m;
        e.t   = t;
        e.f   = f;
        e.b   = b;
        sb.push_back(e);
    endtask

    task automatic check_head();
        exp_t       e;
        logic [8:0] obs;
        logic [8:0] req;
        e   = sb.pop_front();
        obs = {tick & e.m, flag & e.m, busy & e.m};
        req = {e.t & e.m, e.f & e.m, e.b & e.m};
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed tick/flag/busy=%b required %b", e.tag, obs, req);
        end
    endtask

    // Queue expectation, advance one edge, compare.
    task automatic step(input string tag, input logic [2:0] m, input logic [2:0] t,
                        input logic [2:0] f, input logic [2:0] b);
        push(tag, m, t, f, b);
        @(posedge clk);
        #1;
        check_head();
    endtask

    task automatic step_ch(input string tag, input int ch, input logic t, input logic f,
                           input logic b);
        logic [2:0] m;
        logic [2:0] tv;
        logic [2:0] fv;
        logic [2:0] bv;
        m  = 3'b001 << ch;
        tv = {2'b00, t} << ch;
        fv = {2'b00, f} << ch;
        bv = {2'b00, b} << ch;
        step(tag, m, tv, fv, bv);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] per, input logic mode);
        load_wr     = 1'b1;
        load_ch     = ch;
        load_period = per;
        load_mode   = mode;
    endtask

    initial begin
        rst         = 1'b1;
        timer_ena   = '0;
        load_wr     = 1'b0;
        load_ch     = '0;
        load_period = '0;
        load_mode   = 1'b0;
        flag_clr    = '0;

        // Reset state.
        #12;
        push("reset", 3'b111, 3'b000, 3'b000, 3'b000);
        check_head();
        rst = 1'b0;

        // Default period 5, ch0 enabled from edge 1.
        timer_ena = 3'b001;
        for (int k = 1; k <= 15; k++) begin
            step_ch("t1_period5", 0, (k % 5) == 0, k >= 5, 1'b1);
        end

        // Flag clear on a tick edge (set wins), then on a non-tick edge.
        for (int k = 16; k <= 19; k++) begin
            step_ch("t4_pre", 0, 1'b0, 1'b1, 1'b1);
        end
        flag_clr = 3'b001;
        step_ch("t4_clr_on_tick", 0, 1'b1, 1'b1, 1'b1);
        step_ch("t4_clr_no_tick", 0, 1'b0, 1'b0, 1'b1);
        flag_clr = 3'b000;
        step_ch("t4_after_clr", 0, 1'b0, 1'b0, 1'b1);
        timer_ena = 3'b000;
        step_ch("t4_disable", 0, 1'b0, 1'b0, 1'b0);

        // One-shot period 3 on ch1, then re-arm.
        wr(2'd1, 8'd3, 1'b1);
        step_ch("t2_load", 1, 1'b0, 1'b0, 1'b0);
        load_wr   = 1'b0;
        timer_ena = 3'b010;
        step_ch("t2_e1", 1, 1'b0, 1'b0, 1'b1);
        step_ch("t2_e2", 1, 1'b0, 1'b0, 1'b1);
        step_ch("t2_e3_tick", 1, 1'b1, 1'b1, 1'b0);
        step_ch("t2_done_a", 1, 1'b0, 1'b1, 1'b0);
        step_ch("t2_done_b", 1, 1'b0, 1'b1, 1'b0);
        timer_ena = 3'b000;
        step_ch("t2_drop", 1, 1'b0, 1'b1, 1'b0);
        timer_ena = 3'b010;
        step_ch("t2_re_e1", 1, 1'b0, 1'b1, 1'b1);
        step_ch("t2_re_e2", 1, 1'b0, 1'b1, 1'b1);
        step_ch("t2_re_e3_tick", 1, 1'b1, 1'b1, 1'b0);
        step_ch("t2_re_done", 1, 1'b0, 1'b1, 1'b0);
        timer_ena = 3'b000;
        flag_clr  = 3'b010;
        step_ch("t2_clr", 1, 1'b0, 1'b0, 1'b0);
        flag_clr  = 3'b000;

        // Period 0 ticks every enabled cycle; reload mid-run restarts the count.
        wr(2'd0, 8'd0, 1'b0);
        step_ch("t3_load0", 0, 1'b0, 1'b0, 1'b0);
        load_wr   = 1'b0;
        timer_ena = 3'b001;
        for (int k = 1; k <= 4; k++) begin
            step_ch("t3_every", 0, 1'b1, 1'b1, 1'b1);
        end
        wr(2'd0, 8'd2, 1'b0);
        step_ch("t3_reload_edge", 0, 1'b0, 1'b1, 1'b1);
        load_wr = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step_ch("t3_period2", 0, (k % 2) == 0, 1'b1, 1'b1);
        end

        // Independent channels; writes to ch1 and to nonexistent ch3.
        timer_ena = 3'b000;
        step("t6_idle", 3'b111, 3'b000, 3'b001, 3'b000);
        timer_ena = 3'b101;
        for (int k = 1; k <= 12; k++) begin
            load_wr = 1'b0;
            if (k == 2) wr(2'd1, 8'd4, 1'b0);
            if (k == 6) wr(2'd3, 8'd1, 1'b1);
            if (k == 9) wr(2'd3, 8'd0, 1'b0);
            step("t6_spacing", 3'b111,
                 {(k % 5) == 0, 1'b0, (k % 2) == 0},
                 {k >= 5, 1'b0, 1'b1},
                 3'b101);
        end
        load_wr = 1'b0;

        // ch1 must hold period 4 (ch3 writes must not leak into it).
        timer_ena = 3'b010;
        for (int k = 1; k <= 8; k++) begin
            step_ch("t6_ch1_period4", 1, (k % 4) == 0, k >= 4, 1'b1);
        end

        // Asynchronous reset while a tick is in progress.
        timer_ena = 3'b001;
        step_ch("t5_e1", 0, 1'b0, 1'b1, 1'b1);
        step_ch("t5_e2_tick", 0, 1'b1, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        push("t5_async", 3'b111, 3'b000, 3'b000, 3'b000);
        check_head();
        step("t5_hold", 3'b111, 3'b000, 3'b000, 3'b000);
        #2;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step_ch("t5_default", 0, (k % 5) == 0, k >= 5, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
Multi-channel programmable timer, the successor of the fixed-period single-channel pulse divider. Each channel has:
- its own run-time-loadable period;
- periodic or one-shot mode;
- a registered 1-cycle tick and a sticky expiry flag.

It sits between the peripheral bus decode and CPU-visible timer status. Ticks pace UART/LED/delay peripherals.

Parameters:
CHANNELS, 2, number of independent timer channels (1..8)
WIDTH, 24, counter and period width in bits (24 bits holds 1 s at 12 MHz)
DEFAULT_PERIOD, 1200000, reset value of every period register (100 ms at 12 MHz)
CW, $clog2(CHANNELS) min 1, localparam: width of channel select

Ports:
clk  in  1  system clock (12 MHz on iceStick)
rst  in  1  asynchronous, active-high reset
timer_ena  in  CHANNELS  per-channel run enable; level sensitive
load_wr  in  1  write strobe for the period/mode register of channel load_ch
load_ch  in  CW  channel being written
load_period  in  WIDTH  new period, in clk cycles
load_mode  in  1  0 = periodic, 1 = one-shot
flag_clr  in  CHANNELS  per-channel clear of the sticky flag
tick  out  CHANNELS  registered, 1-cycle pulse on expiry
flag  out  CHANNELS  sticky expiry flag
busy  out  CHANNELS  1 while the channel is counting (state RUN)

Behaviour:
- Reset (asynchronous, immediate):
  - all counters 0; all states IDLE;
  - tick = 0, flag = 0, busy = 0;
  - period registers = DEFAULT_PERIOD; mode = periodic.
- Per-channel states:
  - IDLE: counter held at 0.
    - timer_ena = 1 moves to RUN on the same edge.
    - That edge counts as enabled edge 1, so the counter becomes 1.
  - RUN: on each edge with timer_ena = 1:
    - if counter == Peff-1: counter <= 0 and tick <= 1 for the following cycle;
    - else counter <= counter + 1.
    - After expiry, periodic mode stays in RUN; one-shot mode goes to DONE.
  - DONE: counter 0, no ticks, busy = 0. Stays in DONE until timer_ena = 0.
  - timer_ena = 0 in any state: next state IDLE, counter 0 (re-arm).
- Effective period: Peff = period, except period 0 is treated as 1.
  - Peff = 1 gives tick every enabled cycle, with tick held high continuously while enabled in periodic mode.
- Tick timing:
  - With timer_ena high from edge e1, tick is high in the cycle after edge eP, eP+Peff, ... where P = Peff.
  - Tick spacing is exactly Peff cycles.
  - Ticks are registered. There is no combinational path from any input to tick.
- busy = (state == RUN), registered.
- flag:
  - set on the edge that sets tick; cleared by flag_clr;
  - simultaneous set and clear: set wins;
  - flag survives timer_ena = 0.
- Load port:
  - load_wr = 1 writes period and mode of channel load_ch.
  - The same edge clears that channel's counter to 0. State: RUN stays RUN; DONE goes to IDLE if timer_ena = 0, else stays DONE.
  - An in-flight count restarts with the new period. No tick is generated on that edge, even if the old counter was at Peff-1.
  - load_ch >= CHANNELS: write ignored.
  - Other channels are unaffected.
- Channels are fully independent. A write to one channel never disturbs the count of another.
- Counter width is WIDTH. The counter never exceeds Peff-1, so there is no wrap-around beyond the period.
- Reset mid-count: all state cleared and any tick in progress aborted. The channel restarts in IDLE with DEFAULT_PERIOD.

Test Plan:
1. DEFAULT_PERIOD=5, ch0 timer_ena held high from edge 1 -> tick[0] high in cycles after edges 5, 10, 15. flag[0] set after edge 5. busy[0] = 1 throughout.
2. Load ch1 period=3, mode=one-shot, then raise timer_ena[1] -> one tick after edge 3, then busy[1] = 0 and no further ticks. Drop ena 1 cycle and re-raise -> one more tick 3 edges later.
3. Load ch0 period=0 -> tick[0] high every enabled cycle. Load period=2 mid-run -> counter restarts, next tick 2 edges after the write edge.
4. flag_clr[0] asserted on the same edge as a tick -> flag[0] stays 1. flag_clr[0] on a non-tick edge -> flag[0] = 0 next cycle.
5. ch0 running with counter at 3 of 5: assert rst asynchronously between edges -> tick/flag/busy drop immediately. After release, period reads back 5 (first tick 5 enabled edges later).
6. CHANNELS=3: load_wr with load_ch=3 -> no channel's period changes. ch0/ch2 running with different periods keep exact tick spacing during writes to ch1.
